// File: rtl/mem_map_pkg.sv
// Memory map constants, region type and address decode helper for mem_bridge.
package mem_map_pkg;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hF000;

  localparam logic [3:0] LEDR_OFF     = 4'h0;
  localparam logic [3:0] SW_OFF       = 4'h2;
  localparam logic [3:0] CYC_LO_OFF   = 4'h4;
  localparam logic [3:0] CYC_HI_OFF   = 4'h6;
  localparam logic [3:0] CYC_CTRL_OFF = 4'h8;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IO_W   = 10;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_t;

  // RAM wins over MMIO when the two ranges overlap.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic [16:0] ram_bytes,
                                            input logic [15:0] mmio_base);
    if ({1'b0, addr} < ram_bytes) return REG_RAM;
    else if (addr[15:4] == mmio_base[15:4]) return REG_MMIO;
    else return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// CPU memory port: byte address, strobes, write data and registered read return.
interface mem_bridge_if;
  import mem_map_pkg::*;

  logic [15:0]       i_mem_addr;
  logic              i_mem_rd;
  logic              i_mem_wr;
  logic [DATA_W-1:0] i_mem_wrdata;
  logic [DATA_W-1:0] o_mem_rddata;
  logic              o_rd_valid;

  modport master (
    output i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata,
    input  o_mem_rddata, o_rd_valid
  );

  modport slave (
    input  i_mem_addr, i_mem_rd, i_mem_wr, i_mem_wrdata,
    output o_mem_rddata, o_rd_valid
  );
endinterface

// File: rtl/mmio_regs.sv
// MMIO register block: LED register, switch synchronizer, cycle counter and HI snapshot.
module mmio_regs
  import mem_map_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        word_off,
  input  logic [IO_W-1:0]   wrdata,
  input  logic [IO_W-1:0]   i_sw,
  output logic [IO_W-1:0]   o_ledr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [IO_W-1:0]   ledr_q, ledr_d;
  logic [IO_W-1:0]   sw_meta_q, sw_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [3:0]        off;

  assign off = {word_off, 1'b0};

  // Next-state for LED, counter (clear beats increment) and HI snapshot.
  always_comb begin
    ledr_d = ledr_q;
    cnt_d  = cnt_q + CNT_W'(1);
    hi_d   = hi_q;
    if (wr_en && off == LEDR_OFF) ledr_d = wrdata;
    if (wr_en && off == CYC_CTRL_OFF && wrdata[0]) cnt_d = '0;
    if (rd_en && off == CYC_LO_OFF) hi_d = cnt_q[31:16];
  end

  // State registers, including the two-flop switch synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
    end else begin
      ledr_q    <= ledr_d;
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
    end
  end

  // Read mux; write-only and reserved offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (off)
      LEDR_OFF:   rdata_c = DATA_W'(ledr_q);
      SW_OFF:     rdata_c = DATA_W'(sw_sync_q);
      CYC_LO_OFF: rdata_c = cnt_q[15:0];
      CYC_HI_OFF: rdata_c = hi_q;
      default:    rdata_c = '0;
    endcase
  end

  assign o_ledr = ledr_q;

endmodule

// File: rtl/mem_bridge.sv
// Memory-side stage: decodes RAM / MMIO / unmapped, 1-cycle registered read return.
module mem_bridge
  import mem_map_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter string       INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_bridge_if.slave     bus,
  input  logic [IO_W-1:0] i_sw,
  output logic [IO_W-1:0] o_ledr,
  output logic            o_bus_err
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [16:0] RAM_BYTES = 17'(2 * MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  region_t           region;
  logic              rd_acc, wr_acc, ram_we, mmio_rd, mmio_wr;
  logic [AW-1:0]     widx;
  logic [DATA_W-1:0] mmio_rdata_c;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              bus_err_q, bus_err_d;

  // Decode and access qualification; a write always beats a simultaneous read.
  always_comb begin
    region  = decode_region(bus.i_mem_addr, RAM_BYTES, MMIO_BASE);
    widx    = bus.i_mem_addr[AW:1];
    wr_acc  = bus.i_mem_wr;
    rd_acc  = bus.i_mem_rd & ~bus.i_mem_wr;
    ram_we  = wr_acc && (region == REG_RAM);
    mmio_wr = wr_acc && (region == REG_MMIO);
    mmio_rd = rd_acc && (region == REG_MMIO);
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[widx] <= bus.i_mem_wrdata;
  end

  mmio_regs u_mmio (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (mmio_rd),
    .wr_en    (mmio_wr),
    .word_off (bus.i_mem_addr[3:1]),
    .wrdata   (bus.i_mem_wrdata[IO_W-1:0]),
    .i_sw     (i_sw),
    .o_ledr   (o_ledr),
    .rdata_c  (mmio_rdata_c)
  );

  // Read return select, valid pulse and sticky bus error.
  always_comb begin
    rddata_d   = rddata_q;
    rd_valid_d = rd_acc;
    bus_err_d  = bus_err_q;
    if (rd_acc) begin
      case (region)
        REG_RAM:  rddata_d = mem[widx];
        REG_MMIO: rddata_d = mmio_rdata_c;
        default:  rddata_d = '0;
      endcase
    end
    if ((rd_acc || wr_acc) && region == REG_UNMAPPED) bus_err_d = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rddata_q   <= '0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      rddata_q   <= rddata_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus.o_mem_rddata = rddata_q;
  assign bus.o_rd_valid   = rd_valid_q;
  assign o_bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge.
module tb_mem_bridge;

  logic       clk;
  logic       reset_n;
  logic [9:0] i_sw;
  logic [9:0] o_ledr;
  logic       o_bus_err;

  int total;
  int bad;

  mem_bridge_if bus ();

  mem_bridge dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .i_sw      (i_sw),
    .o_ledr    (o_ledr),
    .o_bus_err (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: drive strobes, take the edge, sample point is #1 after it.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data);
    bus.i_mem_rd     = rd;
    bus.i_mem_wr     = wr;
    bus.i_mem_addr   = addr;
    bus.i_mem_wrdata = data;
    @(posedge clk);
    #1;
    bus.i_mem_rd = 1'b0;
    bus.i_mem_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.i_mem_rd = 1'b0;
    bus.i_mem_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      total++;
      if (bus.o_mem_rddata !== 16'h0000 || bus.o_rd_valid !== 1'b0 ||
          o_ledr !== 10'h000 || o_bus_err !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got rd=%h v=%b led=%h err=%b want 0000/0/000/0",
                 i, bus.o_mem_rddata, bus.o_rd_valid, o_ledr, o_bus_err);
      end
    end
  endtask

  task automatic test_ram_rw();
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    total++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_mem_rddata !== 16'h0000) begin
      bad++;
      $display("FAIL write_no_valid got v=%b rd=%h want 0/0000", bus.o_rd_valid, bus.o_mem_rddata);
    end
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'hBEEF || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL read_0010 got %h v=%b want beef/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
    access(1'b1, 1'b0, 16'h0011, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'hBEEF || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL read_0011 got %h v=%b want beef/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
    idle(1);
    total++;
    if (bus.o_mem_rddata !== 16'hBEEF || bus.o_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold got %h v=%b want beef/0", bus.o_mem_rddata, bus.o_rd_valid);
    end
  endtask

  task automatic test_rd_wr_collision();
    access(1'b1, 1'b1, 16'h0020, 16'h1234);
    total++;
    if (bus.o_rd_valid !== 1'b0 || bus.o_mem_rddata !== 16'hBEEF) begin
      bad++;
      $display("FAIL rdwr_drop got v=%b rd=%h want 0/beef", bus.o_rd_valid, bus.o_mem_rddata);
    end
    access(1'b1, 1'b0, 16'h0020, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h1234 || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL rdwr_commit got %h v=%b want 1234/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 16'h0031, 16'hA5A5);
    access(1'b1, 1'b0, 16'h0030, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'hA5A5 || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_read got %h v=%b want a5a5/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
    access(1'b0, 1'b1, 16'h1FFE, 16'h5A5A);
    access(1'b1, 1'b0, 16'h1FFE, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h5A5A || o_bus_err !== 1'b0) begin
      bad++;
      $display("FAIL ram_top_word got %h err=%b want 5a5a/0", bus.o_mem_rddata, o_bus_err);
    end
  endtask

  task automatic test_leds_switches();
    access(1'b0, 1'b1, 16'hF000, 16'h03FF);
    total++;
    if (o_ledr !== 10'h3FF) begin
      bad++;
      $display("FAIL ledr_write got %h want 3ff", o_ledr);
    end
    access(1'b0, 1'b1, 16'hF000, 16'hFC2A);
    access(1'b1, 1'b0, 16'hF000, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h002A || o_ledr !== 10'h02A) begin
      bad++;
      $display("FAIL ledr_readback got %h led=%h want 002a/02a", bus.o_mem_rddata, o_ledr);
    end
    i_sw = 10'h155;
    idle(3);
    access(1'b1, 1'b0, 16'hF002, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0155 || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL sw_read got %h v=%b want 0155/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
    access(1'b0, 1'b1, 16'hF002, 16'h0000);
    access(1'b1, 1'b0, 16'hF00A, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0000 || o_bus_err !== 1'b0 || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL reserved_read got %h err=%b v=%b want 0000/0/1",
               bus.o_mem_rddata, o_bus_err, bus.o_rd_valid);
    end
  endtask

  task automatic test_cycle_counter();
    access(1'b0, 1'b1, 16'hF008, 16'h0001);
    idle(5);
    access(1'b1, 1'b0, 16'hF004, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0005) begin
      bad++;
      $display("FAIL cyc_lo got %h want 0005", bus.o_mem_rddata);
    end
    access(1'b1, 1'b0, 16'hF006, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0000) begin
      bad++;
      $display("FAIL cyc_hi got %h want 0000", bus.o_mem_rddata);
    end
    access(1'b1, 1'b0, 16'hF008, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0000 || bus.o_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_read got %h v=%b want 0000/1", bus.o_mem_rddata, bus.o_rd_valid);
    end
    // Preset the counter just below a 16-bit carry, then read LO and HI.
    bus.i_mem_rd   = 1'b1;
    bus.i_mem_wr   = 1'b0;
    bus.i_mem_addr = 16'hF004;
    force dut.u_mmio.cnt_q = 32'h0001FFFF;
    @(posedge clk);
    #1;
    release dut.u_mmio.cnt_q;
    bus.i_mem_rd = 1'b0;
    total++;
    if (bus.o_mem_rddata !== 16'hFFFF) begin
      bad++;
      $display("FAIL cyc_lo_preset got %h want ffff", bus.o_mem_rddata);
    end
    idle(2);
    access(1'b1, 1'b0, 16'hF006, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0001) begin
      bad++;
      $display("FAIL cyc_hi_snapshot got %h want 0001", bus.o_mem_rddata);
    end
  endtask

  task automatic test_bus_error();
    access(1'b1, 1'b0, 16'h8000, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0000 || bus.o_rd_valid !== 1'b1 || o_bus_err !== 1'b1) begin
      bad++;
      $display("FAIL unmapped_read got %h v=%b err=%b want 0000/1/1",
               bus.o_mem_rddata, bus.o_rd_valid, o_bus_err);
    end
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'hBEEF || o_bus_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got %h err=%b want beef/1", bus.o_mem_rddata, o_bus_err);
    end
    access(1'b0, 1'b1, 16'h8000, 16'h7777);
    access(1'b1, 1'b0, 16'h8000, 16'h0000);
    total++;
    if (bus.o_mem_rddata !== 16'h0000 || o_bus_err !== 1'b1) begin
      bad++;
      $display("FAIL unmapped_write_drop got %h err=%b want 0000/1", bus.o_mem_rddata, o_bus_err);
    end
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    reset_n = 1'b0;
    #1;
    total++;
    if (o_bus_err !== 1'b0 || bus.o_mem_rddata !== 16'h0000 || bus.o_rd_valid !== 1'b0 ||
        o_ledr !== 10'h000) begin
      bad++;
      $display("FAIL async_reset got err=%b rd=%h v=%b led=%h want 0/0000/0/000",
               o_bus_err, bus.o_mem_rddata, bus.o_rd_valid, o_ledr);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    total++;
    if (o_bus_err !== 1'b0) begin
      bad++;
      $display("FAIL err_after_reset got %b want 0", o_bus_err);
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    reset_n          = 1'b0;
    i_sw             = 10'h000;
    bus.i_mem_rd     = 1'b0;
    bus.i_mem_wr     = 1'b0;
    bus.i_mem_addr   = 16'h0000;
    bus.i_mem_wrdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    test_reset();
    test_ram_rw();
    test_rd_wr_collision();
    test_back_to_back();
    test_leds_switches();
    test_cycle_counter();
    test_bus_error();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
